// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle controller (master) and its datapath
// and memory (slave).
interface multicycle_ctrl_if #(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                iord;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic                reg_write;
    logic                mem2reg;
    logic [1:0]          alusrc_b;
    logic [ALUOP_W-1:0]  aluop;
    logic                fault;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem2reg,
               alusrc_b, aluop, fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem2reg,
               alusrc_b, aluop, fault
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller: FETCH/DECODE/EXEC/MEM/WB with memory-wait timeout and sticky
// fault. Define MC_CTRL_JAL_EN to support JAL (opcode 1101111); otherwise it traps.
module multicycle_ctrl #(
    parameter int unsigned OPCODE_W    = 7,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned TMO_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 12
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

    localparam logic [OPCODE_W-1:0] OpR   = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OpI   = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OpLd  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OpSt  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OpBeq = OPCODE_W'(7'b1100011);
`ifdef MC_CTRL_JAL_EN
    localparam logic [OPCODE_W-1:0] OpJal = OPCODE_W'(7'b1101111);
`endif

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;
    logic                fault_q, fault_d;
    logic                legal, timeout;

    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem2reg;
    logic [1:0] alusrc_b, aluop;

    always_comb begin
        legal = 1'b0;
        case (bus.opcode)
            OpR, OpI, OpLd, OpSt, OpBeq: legal = 1'b1;
`ifdef MC_CTRL_JAL_EN
            OpJal:                       legal = 1'b1;
`endif
            default:                     legal = 1'b0;
        endcase
    end

    // Last tolerated not-ready cycle; a ready in this same cycle still completes the access.
    assign timeout = !bus.mem_ready && (cnt_q == TMO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = '0;
        fault_d   = fault_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        mem2reg   = 1'b0;
        alusrc_b  = 2'b00;
        aluop     = 2'b00;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    alusrc_b = 2'b01;
                    state_d  = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            StDecode: begin
                op_d    = bus.opcode;
                state_d = legal ? StExec : StTrap;
            end
            StExec: begin
                state_d = StWb;
                case (op_q)
                    OpR: begin
                        alusrc_b = 2'b00;
                        aluop    = 2'b10;
                    end
                    OpI: begin
                        alusrc_b = 2'b10;
                        aluop    = 2'b11;
                    end
                    OpLd, OpSt: begin
                        alusrc_b = 2'b10;
                        state_d  = StMem;
                    end
                    OpBeq: begin
                        aluop    = 2'b01;
                        pc_write = bus.zero;
                        pc_src   = 1'b1;
                        state_d  = StFetch;
                    end
`ifdef MC_CTRL_JAL_EN
                    OpJal: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        alusrc_b = 2'b10;
                    end
`endif
                    default: state_d = StTrap;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op_q == OpSt);
                if (bus.mem_ready) begin
                    state_d = (op_q == OpSt) ? StFetch : StWb;
                end else if (timeout) begin
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            StWb: begin
                reg_write = 1'b1;
                mem2reg   = (op_q == OpLd);
                state_d   = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase

        if (state_d == StTrap) fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            op_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Reset holds every output low, including the FETCH request.
    assign bus.mem_req   = rst_n & mem_req;
    assign bus.mem_we    = rst_n & mem_we;
    assign bus.iord      = rst_n & iord;
    assign bus.ir_write  = rst_n & ir_write;
    assign bus.pc_write  = rst_n & pc_write;
    assign bus.pc_src    = rst_n & pc_src;
    assign bus.reg_write = rst_n & reg_write;
    assign bus.mem2reg   = rst_n & mem2reg;
    assign bus.alusrc_b  = rst_n ? alusrc_b : 2'b00;
    assign bus.aluop     = rst_n ? ALUOP_W'(aluop) : '0;
    assign bus.fault     = rst_n & fault_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-cycle output vectors come from an instruction-level
// model (phase sequence per opcode, wait counts, timeout rule). Honours MC_CTRL_JAL_EN.
module tb_multicycle_ctrl;
    localparam int TMO = 12;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSt  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;
`ifdef MC_CTRL_JAL_EN
    localparam bit JalEn = 1'b1;
`else
    localparam bit JalEn = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   trapped;

    multicycle_ctrl_if #(.OPCODE_W(7), .ALUOP_W(2)) bus ();

    multicycle_ctrl #(
        .OPCODE_W   (7),
        .ALUOP_W    (2),
        .TMO_W      (4),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    logic [12:0] obs;
    assign obs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                  bus.reg_write, bus.mem2reg, bus.alusrc_b, bus.aluop, bus.fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [12:0] ov(bit req, bit we, bit io, bit irw, bit pcw, bit pcs,
                                       bit rw, bit m2r, logic [1:0] bs, logic [1:0] ao, bit f);
        return {req, we, io, irw, pcw, pcs, rw, m2r, bs, ao, f};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, compare outputs mid-cycle, advance to just after the next edge.
    task automatic step(string tag, bit rdy, bit z, logic [12:0] exp);
        bus.mem_ready = rdy;
        bus.zero      = z;
        @(negedge clk);
        check(tag, {19'd0, obs}, {19'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.opcode = 7'($urandom);
            step("in_reset", 1'b1, rb(), 13'd0);
        end
        rst_n   = 1'b1;
        trapped = 1'b0;
    endtask

    task automatic recover(int n);
        for (int i = 0; i < n; i++) begin
            bus.opcode = 7'($urandom);
            step("trap_hold", rb(), rb(), ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
        end
        do_reset();
    endtask

    // One instruction: fw/mw = not-ready cycles before ready in FETCH/MEM (>= TMO means timeout),
    // zsel 0/1 fixes the ALU zero flag in EXEC, 2 randomizes it; abort resets mid-MEM.
    task automatic run_instr(logic [6:0] op, int fw, int mw, int zsel, bit abort);
        int          waits;
        bit          z;
        bit          st;
        logic [12:0] mem_v;

        bus.opcode = 7'($urandom);
        waits = (fw < TMO) ? fw : TMO;
        for (int i = 0; i < waits; i++)
            step("fetch_wait", 1'b0, rb(), ov(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        if (fw >= TMO) begin
            trapped = 1'b1;
            return;
        end
        step("fetch_rdy", 1'b1, rb(), ov(1, 0, 0, 1, 1, 0, 0, 0, 2'b01, 2'b00, 0));

        bus.opcode = op;
        step("decode", rb(), rb(), 13'd0);
        bus.opcode = 7'($urandom);
        if (!(op inside {OpR, OpI, OpLd, OpSt, OpBeq} || (JalEn && op == OpJal))) begin
            trapped = 1'b1;
            return;
        end

        z = (zsel == 2) ? rb() : (zsel == 1);
        case (op)
            OpR: begin
                step("exec_r", rb(), z, ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0));
                step("wb_r", rb(), rb(), ov(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
            end
            OpI: begin
                step("exec_i", rb(), z, ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b11, 0));
                step("wb_i", rb(), rb(), ov(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
            end
            OpBeq: step("exec_beq", rb(), z, ov(0, 0, 0, 0, z, 1, 0, 0, 2'b00, 2'b01, 0));
            OpJal: begin
                step("exec_jal", rb(), z, ov(0, 0, 0, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0));
                step("wb_jal", rb(), rb(), ov(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
            end
            default: begin
                st    = (op == OpSt);
                mem_v = ov(1, st, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
                step("exec_mem", rb(), z, ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
                waits = (mw < TMO) ? mw : TMO;
                for (int i = 0; i < waits; i++) begin
                    if (abort && i == 1) begin
                        bus.mem_ready = 1'b1;
                        #2 rst_n = 1'b0;
                        #1 check("mem_abort", {19'd0, obs}, 32'd0);
                        @(posedge clk);
                        #1 rst_n = 1'b1;
                        return;
                    end
                    step("mem_wait", 1'b0, rb(), mem_v);
                end
                if (mw >= TMO) begin
                    trapped = 1'b1;
                    return;
                end
                step("mem_rdy", 1'b1, rb(), mem_v);
                if (!st) step("wb_ld", rb(), rb(), ov(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0));
            end
        endcase
    endtask

    task automatic run(logic [6:0] op, int fw, int mw, int zsel, bit abort);
        run_instr(op, fw, mw, zsel, abort);
        if (trapped) recover(20);
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 15) < 13) ? int'($urandom_range(0, 3))
                                            : int'($urandom_range(10, 13));
    endfunction

    initial begin
        logic [6:0] ops[6];
        logic [6:0] op;
        int         mw;
        ops = '{OpR, OpI, OpLd, OpSt, OpBeq, OpJal};
        n_tests       = 0;
        n_fail        = 0;
        trapped       = 1'b0;
        rst_n         = 1'b1;
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run(OpR, 0, 0, 2, 1'b0);
        run(OpLd, 0, 3, 2, 1'b0);
        run(OpBeq, 0, 0, 1, 1'b0);
        run(OpBeq, 0, 0, 0, 1'b0);
        run(OpI, 2, 0, 2, 1'b0);
        run(OpSt, 1, 2, 2, 1'b0);
        run(7'b1111111, 0, 0, 2, 1'b0);
        run(OpR, 12, 0, 2, 1'b0);
        run(OpR, 11, 0, 2, 1'b0);
        run(OpJal, 0, 0, 2, 1'b0);
        run(OpSt, 0, 12, 2, 1'b0);
        run(OpLd, 0, 11, 2, 1'b0);
        run(OpLd, 0, 5, 2, 1'b1);
        run(OpR, 0, 0, 2, 1'b0);

        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            mw = pick_wait();
            run(op, pick_wait(), mw, 2, ($urandom_range(0, 19) == 0) && mw >= 2 && mw < TMO);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- OPCODE_W, 7, opcode field width.
- ALUOP_W, 2, aluop width (≥2). Upper bits SHALL be driven 0 when ALUOP_W>2.
- TMO_W, 4, memory-wait timeout counter width.
- MEM_TIMEOUT, 12, maximum wait cycles for mem_ready (<2^TMO_W).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all state changes on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- opcode, in, OPCODE_W, instruction[6:0] from IR; valid in DECODE.
- zero, in, 1, ALU zero flag.
- mem_ready, in, 1, memory handshake completion.
- mem_req, out, 1, memory access request.
- mem_we, out, 1, memory write.
- iord, out, 1, address select: 0=PC, 1=ALU result.
- ir_write, out, 1, IR load.
- pc_write, out, 1, PC load.
- pc_src, out, 1, PC source: 0=PC+4, 1=branch/jump target.
- reg_write, out, 1, register file write.
- mem2reg, out, 1, writeback source: 1=memory data.
- alusrc_b, out, 2, ALU B source: 00=rs2, 01=4, 10=imm.
- aluop, out, ALUOP_W, ALU op: 00=add, 01=sub/compare, 10=R-funct, 11=I-funct.
- fault, out, 1, sticky illegal-opcode or memory-timeout flag.

Function
REQ-003 The FSM SHALL have exactly these states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-004 FETCH SHALL assert mem_req=1 and iord=0. On the cycle with mem_ready=1, it SHALL assert ir_write=1, pc_write=1, pc_src=0, alusrc_b=01, and move to DECODE.
REQ-005 DECODE SHALL latch opcode into op_q and go to EXEC. Unsupported opcodes SHALL go to TRAP.
REQ-006 Opcode 0110011 (R-type) SHALL take EXEC (alusrc_b=00, aluop=10) then WB (reg_write=1, mem2reg=0).
REQ-007 Opcode 0010011 (I-ALU) SHALL take EXEC (alusrc_b=10, aluop=11) then WB (reg_write=1, mem2reg=0).
REQ-008 Opcode 0000011 (load) SHALL take EXEC (alusrc_b=10, aluop=00), then MEM (mem_req=1, iord=1, mem_we=0, held until mem_ready), then WB (reg_write=1, mem2reg=1).
REQ-009 Opcode 0100011 (store) SHALL take EXEC (alusrc_b=10, aluop=00), then MEM (mem_req=1, iord=1, mem_we=1, held until mem_ready), then FETCH.
REQ-010 Opcode 1100011 (beq) SHALL take EXEC with alusrc_b=00, aluop=01, and pc_write=zero, pc_src=1, then go to FETCH.
REQ-011 Minimum latency with zero-wait memory (mem_ready high in the first request cycle) SHALL be: beq 3, R/I/store 4, load 5 cycles.
REQ-012 Outputs SHALL decode from state and op_q, except ir_write/pc_write in FETCH (gated by mem_ready) and pc_write in beq EXEC (gated by zero). Every output not listed for a state SHALL be 0.
REQ-013 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0. Reaching MEM_TIMEOUT SHALL move the FSM to TRAP with no write enables asserted. mem_ready in the same cycle as the timeout SHALL win.
REQ-014 TRAP SHALL hold fault=1 with all other outputs 0 until reset.
REQ-015 mem_req SHALL stay high and iord/mem_we stable from the first request cycle through the mem_ready cycle inclusive.

Reset
REQ-016 rst_n low SHALL asynchronously force: state=FETCH, op_q=0, counter=0, fault=0.
REQ-017 While rst_n is low, all outputs SHALL be 0, including mem_req.
REQ-018 The first request SHALL be issued in the first cycle after rst_n deasserts.
REQ-019 Reset mid-MEM SHALL abort the access without asserting reg_write or pc_write.

Configuration
REQ-020 With MC_CTRL_JAL_EN defined, opcode 1101111 SHALL take EXEC (pc_write=1, pc_src=1, alusrc_b=10, aluop=00) then WB (reg_write=1, mem2reg=0; datapath writes the old PC+4). Minimum latency SHALL be 4 cycles.
REQ-021 With MC_CTRL_JAL_EN undefined, opcode 1101111 SHALL be illegal and go to TRAP.

Verification
REQ-022 Reset release, then R-type 0110011 with mem_ready tied 1 -> states FETCH, DECODE, EXEC, WB. Exactly one reg_write pulse in cycle 4, mem2reg=0; fault stays 0.
REQ-023 Load 0000011, mem_ready low for 3 MEM cycles -> mem_req/iord held 4 cycles in MEM, then WB with reg_write=1, mem2reg=1.
REQ-024 beq with zero=1, then zero=0 -> pc_write=1, pc_src=1 in EXEC for the first; pc_write=0 in EXEC for the second; each returns to FETCH after 3 cycles.
REQ-025 Opcode 1111111 -> TRAP after DECODE, fault=1 held 20 cycles, all enables 0; rst_n pulse -> fault=0, FETCH.
REQ-026 mem_ready held 0 in FETCH with MEM_TIMEOUT=12 -> TRAP entered after 12 request cycles. Repeat with mem_ready=1 in cycle 12 -> DECODE, not TRAP.
REQ-027 Opcode 1101111 built with and without MC_CTRL_JAL_EN -> 4-cycle JAL with pc_write and reg_write vs. TRAP with fault=1.
